// File: rtl/accel_disp_pkg.sv
// Shared constants, types and glyph table for the accelerometer 7-segment display.
package accel_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;

  localparam int unsigned NUM_SLOTS = 5;

  typedef enum logic [2:0] {
    SLOT_ONES      = 3'd0,
    SLOT_TENS      = 3'd1,
    SLOT_HUNDREDS  = 3'd2,
    SLOT_THOUSANDS = 3'd3,
    SLOT_SIGN      = 3'd4
  } slot_t;

  typedef struct packed {
    logic       negative;
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } sample_t;

  // Active-low glyphs, bit 0 = segment a .. bit 6 = segment g.
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 7'h40;
      4'd1:    digit_glyph = 7'h79;
      4'd2:    digit_glyph = 7'h24;
      4'd3:    digit_glyph = 7'h30;
      4'd4:    digit_glyph = 7'h19;
      4'd5:    digit_glyph = 7'h12;
      4'd6:    digit_glyph = 7'h02;
      4'd7:    digit_glyph = 7'h78;
      4'd8:    digit_glyph = 7'h00;
      4'd9:    digit_glyph = 7'h10;
      default: digit_glyph = SEG_E;
    endcase
  endfunction

endpackage

// File: rtl/accel_seg_display_if.sv
// Sample bus from the binary-to-BCD stage: load strobe, sign and four BCD digits.
interface accel_seg_display_if;
  logic       load;
  logic       negative;
  logic [3:0] thousands;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  modport master (output load, negative, thousands, hundreds, tens, ones);
  modport slave  (input  load, negative, thousands, hundreds, tens, ones);
endinterface

// File: rtl/accel_seg_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking and error flag.
module bcd_to_7seg
  import accel_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg_n,
  output logic       err
);

  // Dark when blanked; 'E' and error for non-BCD values in a lit position.
  always_comb begin
    seg_n = SEG_BLANK;
    err   = 1'b0;
    if (!blank) begin
      if (digit > 4'd9) begin
        seg_n = SEG_E;
        err   = 1'b1;
      end else begin
        seg_n = digit_glyph(digit);
      end
    end
  end

endmodule

// File: rtl/accel_seg_display.sv
// Double-buffered, time-multiplexed common-anode display driver for a signed 4-digit mG value.
module accel_seg_display
  import accel_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset_n,
  accel_seg_display_if.slave  smp,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic [7:0]          an_n,
  output logic                frame_start,
  output logic                bcd_err
);

  localparam int unsigned   PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;
  logic          wrap;
  slot_t         slot_q;
  slot_t         slot_d;
  sample_t       pending;
  sample_t       display;
  logic          pending_valid;
  logic          transfer;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic [6:0]    dec_seg;
  logic          dec_err;
  logic [6:0]    slot_seg;
  logic [7:0]    anode_sel;

  assign wrap     = (presc == PRESC_LAST);
  assign transfer = wrap && (slot_q == SLOT_SIGN) && pending_valid;
  assign dp_n     = 1'b1;

  // Prescaler: one digit slot every REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc <= '0;
    else if (wrap) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Slot state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) slot_q <= SLOT_ONES;
    else          slot_q <= slot_d;
  end

  // Slot sequencing: ones, tens, hundreds, thousands, sign, then back to ones.
  always_comb begin
    slot_d = slot_q;
    if (wrap) begin
      if (slot_q == SLOT_SIGN) slot_d = SLOT_ONES;
      else                     slot_d = slot_t'(slot_q + 3'd1);
    end
  end

  // Pending/display double buffer; a load on the transfer edge stays pending for the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= '0;
      display       <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (transfer) display <= pending;
      if (smp.load) begin
        pending       <= '{negative:  smp.negative,
                           thousands: smp.thousands,
                           hundreds:  smp.hundreds,
                           tens:      smp.tens,
                           ones:      smp.ones};
        pending_valid <= 1'b1;
      end else if (transfer) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Digit selection and leading-zero blanking for the current slot.
  always_comb begin
    cur_digit = display.ones;
    cur_blank = 1'b0;
    case (slot_q)
      SLOT_ONES: cur_digit = display.ones;
      SLOT_TENS: begin
        cur_digit = display.tens;
        cur_blank = (display.thousands == 4'd0) && (display.hundreds == 4'd0) &&
                    (display.tens == 4'd0);
      end
      SLOT_HUNDREDS: begin
        cur_digit = display.hundreds;
        cur_blank = (display.thousands == 4'd0) && (display.hundreds == 4'd0);
      end
      SLOT_THOUSANDS: begin
        cur_digit = display.thousands;
        cur_blank = (display.thousands == 4'd0);
      end
      default: cur_blank = 1'b1;
    endcase
  end

  bcd_to_7seg u_dec (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg_n (dec_seg),
    .err   (dec_err)
  );

  // Sign slot overrides the decoder; anode select is one-cold on the slot index.
  always_comb begin
    slot_seg  = dec_seg;
    if (slot_q == SLOT_SIGN) slot_seg = display.negative ? SEG_MINUS : SEG_BLANK;
    anode_sel = ~(8'h01 << slot_q);
  end

  // Output registers: blank on the wrap so every slot opens with one dark cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n       <= SEG_BLANK;
      an_n        <= '1;
      frame_start <= 1'b0;
      bcd_err     <= 1'b0;
    end else begin
      frame_start <= transfer;
      if (wrap) begin
        seg_n <= SEG_BLANK;
        an_n  <= '1;
      end else if (presc == '0) begin
        seg_n <= slot_seg;
        an_n  <= anode_sel;
        if (dec_err) bcd_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accel_seg_display.sv
// Directed self-checking bench for accel_seg_display with REFRESH_DIV=4 (20-cycle frames).
module tb_accel_seg_display;

  logic       clk;
  logic       reset_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [7:0] an_n;
  logic       frame_start;
  logic       bcd_err;

  int checks = 0;
  int errors = 0;

  logic [6:0] cap_seg [8];
  logic [7:0] cap_seen;
  int         cap_fs;
  logic [7:0] prev_an = 8'hFF;

  accel_seg_display_if smp ();

  accel_seg_display #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .smp         (smp),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .frame_start (frame_start),
    .bcd_err     (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Every cycle: at most one anode low, digits 7..5 dark, and a blank between anode changes.
  always @(negedge clk) begin
    if (reset_n) begin
      checks = checks + 1;
      if ($countones(~an_n) > 1 || an_n[7:5] !== 3'b111) begin
        errors = errors + 1;
        $display("FAIL an_onehot: an_n=%h", an_n);
      end
      checks = checks + 1;
      if (prev_an != 8'hFF && an_n != 8'hFF && an_n != prev_an) begin
        errors = errors + 1;
        $display("FAIL blank_gap: an_n went %h -> %h without a blank cycle", prev_an, an_n);
      end
      prev_an <= an_n;
    end else begin
      prev_an <= 8'hFF;
    end
  end

  task automatic load_sample(input logic neg, input logic [3:0] th, input logic [3:0] hu,
                             input logic [3:0] te, input logic [3:0] on);
    smp.negative  = neg;
    smp.thousands = th;
    smp.hundreds  = hu;
    smp.tens      = te;
    smp.ones      = on;
    smp.load      = 1'b1;
    @(negedge clk);
    smp.load      = 1'b0;
  endtask

  // Waits (bounded) for frame_start, checking the current sample first.
  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (frame_start) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Samples n consecutive cycles starting now; records the segments seen on each anode.
  task automatic capture(input int n);
    cap_seen = '0;
    cap_fs   = 0;
    for (int k = 0; k < 8; k++) cap_seg[k] = 7'h7F;
    for (int i = 0; i < n; i++) begin
      if (frame_start) cap_fs++;
      for (int k = 0; k < 8; k++) begin
        if (an_n[k] == 1'b0) begin
          cap_seg[k]  = seg_n;
          cap_seen[k] = 1'b1;
        end
      end
      if (i + 1 < n) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [6:0] e [5];
    e = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    reset_n = 1'b0;
    smp.load = 1'b0; smp.negative = 1'b0;
    smp.thousands = '0; smp.hundreds = '0; smp.tens = '0; smp.ones = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (an_n !== 8'hFF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_start !== 1'b0 ||
        bcd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: an_n=%h seg_n=%h dp_n=%b fs=%b err=%b, want FF 7F 1 0 0",
               an_n, seg_n, dp_n, frame_start, bcd_err);
    end
    reset_n = 1'b1;
    capture(20);
    checks++;
    if (cap_seen[4:0] !== 5'h1F || cap_fs != 0) begin
      errors++;
      $display("FAIL reset_frame_anodes: seen=%h fs=%0d, want 1F 0", cap_seen, cap_fs);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cap_seg[k] !== e[k]) begin
        errors++;
        $display("FAIL reset_frame_digit%0d: got %h want %h", k, cap_seg[k], e[k]);
      end
    end
  endtask

  task automatic show_and_check(input string name, input logic neg, input logic [3:0] th,
                                input logic [3:0] hu, input logic [3:0] te, input logic [3:0] on,
                                input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                                input logic [6:0] e3, input logic [6:0] e4);
    bit ok;
    logic [6:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    repeat (2) @(negedge clk);
    load_sample(neg, th, hu, te, on);
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_frame_start: no frame_start within 60 cycles", name);
    end
    capture(20);
    checks++;
    if (cap_seen[4:0] !== 5'h1F) begin
      errors++;
      $display("FAIL %s_anodes: seen=%h want 1F", name, cap_seen);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cap_seg[k] !== e[k]) begin
        errors++;
        $display("FAIL %s_digit%0d: got %h want %h", name, k, cap_seg[k], e[k]);
      end
    end
  endtask

  task automatic test_digits;
    show_and_check("neg2048", 1'b1, 4'd2, 4'd0, 4'd4, 4'd8,
                   7'h00, 7'h19, 7'h40, 7'h24, 7'h3F);
    checks++;
    if (bcd_err !== 1'b0) begin
      errors++;
      $display("FAIL digits_bcd_err: got %b want 0", bcd_err);
    end
  endtask

  task automatic test_blanking;
    show_and_check("pos0007", 1'b0, 4'd0, 4'd0, 4'd0, 4'd7,
                   7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    show_and_check("pos0305", 1'b0, 4'd0, 4'd3, 4'd0, 4'd5,
                   7'h12, 7'h40, 7'h30, 7'h7F, 7'h7F);
  endtask

  task automatic test_last_wins;
    bit ok;
    logic [6:0] e [5];
    e = '{7'h40, 7'h40, 7'h30, 7'h7F, 7'h3F};
    repeat (3) @(negedge clk);
    load_sample(1'b0, 4'd0, 4'd0, 4'd1, 4'd2);
    repeat (2) @(negedge clk);
    load_sample(1'b1, 4'd0, 4'd3, 4'd0, 4'd0);
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL last_wins_frame_start: no frame_start within 60 cycles");
    end
    capture(20);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cap_seg[k] !== e[k]) begin
        errors++;
        $display("FAIL last_wins_digit%0d: got %h want %h", k, cap_seg[k], e[k]);
      end
    end
    checks++;
    if (cap_fs != 1) begin
      errors++;
      $display("FAIL last_wins_pulses: got %0d frame_start pulses want 1", cap_fs);
    end
    capture(20);
    checks++;
    if (cap_fs != 0) begin
      errors++;
      $display("FAIL idle_frame_pulses: got %0d frame_start pulses want 0", cap_fs);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [6:0] eb [5];
    logic [6:0] ec [5];
    eb = '{7'h02, 7'h12, 7'h19, 7'h7F, 7'h3F};
    ec = '{7'h40, 7'h40, 7'h40, 7'h79, 7'h7F};
    repeat (2) @(negedge clk);
    load_sample(1'b0, 4'd0, 4'd0, 4'd0, 4'd1);
    wait_fs(ok);
    // Now in cycle 0 of a frame; place the third load on cycle 19, the transfer edge.
    load_sample(1'b1, 4'd0, 4'd4, 4'd5, 4'd6);
    repeat (18) @(negedge clk);
    load_sample(1'b0, 4'd1, 4'd0, 4'd0, 4'd0);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL coincident_transfer_pulse: frame_start=%b want 1", frame_start);
    end
    capture(20);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cap_seg[k] !== eb[k]) begin
        errors++;
        $display("FAIL coincident_old_digit%0d: got %h want %h", k, cap_seg[k], eb[k]);
      end
    end
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL coincident_next_frame_start: no frame_start within 60 cycles");
    end
    capture(20);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cap_seg[k] !== ec[k]) begin
        errors++;
        $display("FAIL coincident_new_digit%0d: got %h want %h", k, cap_seg[k], ec[k]);
      end
    end
  endtask

  task automatic test_bcd_err;
    repeat (1) @(negedge clk);
    checks++;
    if (bcd_err !== 1'b0) begin
      errors++;
      $display("FAIL bcd_err_before: got %b want 0", bcd_err);
    end
    show_and_check("badC000", 1'b0, 4'hC, 4'd0, 4'd0, 4'd0,
                   7'h40, 7'h40, 7'h40, 7'h06, 7'h7F);
    checks++;
    if (bcd_err !== 1'b1) begin
      errors++;
      $display("FAIL bcd_err_set: got %b want 1", bcd_err);
    end
    show_and_check("pos0001", 1'b0, 4'd0, 4'd0, 4'd0, 4'd1,
                   7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    checks++;
    if (bcd_err !== 1'b1) begin
      errors++;
      $display("FAIL bcd_err_sticky: got %b want 1", bcd_err);
    end
  endtask

  task automatic test_async_reset;
    bit lit;
    logic [6:0] e [5];
    e = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    repeat (2) @(negedge clk);
    load_sample(1'b1, 4'd0, 4'd9, 4'd9, 4'd9);
    lit = 1'b0;
    for (int i = 0; i < 20 && !lit; i++) begin
      @(negedge clk);
      if (an_n != 8'hFF) lit = 1'b1;
    end
    checks++;
    if (!lit) begin
      errors++;
      $display("FAIL mid_slot_setup: no driven anode within 20 cycles");
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 8'hFF || seg_n !== 7'h7F || frame_start !== 1'b0 || bcd_err !== 1'b0 ||
        dp_n !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: an_n=%h seg_n=%h fs=%b err=%b dp_n=%b, want FF 7F 0 0 1",
               an_n, seg_n, frame_start, bcd_err, dp_n);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    capture(25);
    checks++;
    if (cap_fs != 0) begin
      errors++;
      $display("FAIL reset_clears_pending: got %0d frame_start pulses want 0", cap_fs);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cap_seg[k] !== e[k]) begin
        errors++;
        $display("FAIL post_reset_digit%0d: got %h want %h", k, cap_seg[k], e[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_blanking();
    test_last_wins();
    test_back_to_back();
    test_bcd_err();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
